aes128_decrypt_iter: RTL and testbench

Iterative, handshaked AES-128 decryption engine built around the team's single-round inverse datapath. It accepts one 128-bit ciphertext plus the full 11-entry expanded key schedule, then runs the 10 inverse rounds over several clock cycles with a configurable number of rounds per cycle. It sits between the key-expansion block, which supplies the schedule, and the downstream consumer through valid/ready handshakes on both sides.

---
 rtl/aes128_decrypt_iter_if.sv | 12 +
 rtl/aes128_decrypt_iter.sv | 117 +++++++++++
 tb/tb_aes128_decrypt_iter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes128_decrypt_iter_if.sv
// aes128_decrypt_iter_if: ciphertext/schedule input and plaintext output handshakes
interface aes128_decrypt_iter_if;
  logic [127:0] in;
  logic [1407:0] keys;
  logic in_valid;
  logic in_ready;
  logic [127:0] out;
  logic out_valid;
  logic out_ready;
  modport master (output in, keys, in_valid, out_ready, input in_ready, out, out_valid);
  modport slave (input in, keys, in_valid, out_ready, output in_ready, out, out_valid);
endinterface

// File: rtl/aes128_decrypt_iter.sv
// aes128_decrypt_iter: iterative AES-128 decryption, UNROLL inverse rounds per cycle
module aes128_decrypt_iter #(
  parameter int UNROLL = 1
) (
  input logic clk,
  input logic rst_n,
  aes128_decrypt_iter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;
  fsm_t fsm, fsmNext;
  logic [3:0] cnt;
  logic [127:0] state_reg, chain;
  logic [1407:0] key_reg;

  if (UNROLL != 1 && UNROLL != 3 && UNROLL != 9) begin : g_badUnroll
    $error("aes128_decrypt_iter: UNROLL must be 1, 3 or 9");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p ^= b[i] ? x : 8'h00;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // inverse S-box = GF(2^8) inverse (x^254) of the inverse affine transform
  function automatic logic [7:0] invSbox(input logic [7:0] a);
    logic [7:0] p, r;
    p = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [127:0] invSubShift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = invSbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] invMix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {
        gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
        gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
        gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
        gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    end
    return o;
  endfunction

  function automatic logic [127:0] roundKey(input logic [1407:0] ks, input logic [3:0] k);
    return (k > 4'd10) ? '0 : ks[int'(k)*128 +: 128];
  endfunction

  always_comb begin
    chain = state_reg;
    for (int j = 0; j < UNROLL; j++)
      chain = invMix(invSubShift(chain) ^ roundKey(key_reg, cnt - 4'(j)));
  end

  always_comb begin
    fsmNext = fsm;
    case (fsm)
      IDLE: fsmNext = bus.in_valid ? ROUND : IDLE;
      ROUND: fsmNext = (cnt == 4'(UNROLL)) ? FINAL : ROUND;
      FINAL: fsmNext = DONE;
      DONE: fsmNext = bus.out_ready ? IDLE : DONE;
    endcase
  end

  assign bus.in_ready = fsm == IDLE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm <= IDLE;
      cnt <= '0;
      state_reg <= '0;
      key_reg <= '0;
      bus.out <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      fsm <= fsmNext;
      if (fsm == IDLE && bus.in_valid) begin
        state_reg <= bus.in ^ bus.keys[1407 -: 128];
        key_reg <= bus.keys;
        cnt <= 4'd9;
      end
      if (fsm == ROUND) begin
        state_reg <= chain;
        cnt <= cnt - 4'(UNROLL);
      end
      if (fsm == FINAL) begin
        bus.out <= invSubShift(state_reg) ^ key_reg[127:0];
        bus.out_valid <= 1'b1;
      end
      if (fsm == DONE && bus.out_ready) bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// tb_aes128_decrypt_iter: directed + random checks of the iterative AES-128 decryptor
// against a forward-cipher reference (random plaintext encrypted, then decrypted by the DUT).
module tb_aes128_decrypt_iter;
  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [127:0] ct = '0;
  logic [1407:0] ks = '0;
  logic inValid = 1'b0;
  logic outReady = 1'b1;
  int compared = 0;
  int mismatched = 0;
  logic [127:0] sb[$];
  logic [7:0] sbox[256];

  always #5 clk = ~clk;

  aes128_decrypt_iter_if b1 ();
  aes128_decrypt_iter_if b3 ();
  aes128_decrypt_iter_if b9 ();
  assign b1.in = ct;
  assign b1.keys = ks;
  assign b1.in_valid = inValid;
  assign b1.out_ready = outReady;
  assign b3.in = ct;
  assign b3.keys = ks;
  assign b3.in_valid = inValid;
  assign b3.out_ready = outReady;
  assign b9.in = ct;
  assign b9.keys = ks;
  assign b9.in_valid = inValid;
  assign b9.out_ready = outReady;

  aes128_decrypt_iter #(.UNROLL(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  aes128_decrypt_iter #(.UNROLL(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));
  aes128_decrypt_iter #(.UNROLL(9)) u9 (.clk(clk), .rst_n(rst_n), .bus(b9));

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] subShift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = sbox[s[127-8*(4*((c+r)%4)+r) -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] mixCols(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3, a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3, xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o;
  endfunction

  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0] rc;
    logic [1407:0] k;
    rc = 8'h01;
    k = '0;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) k[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return k;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [1407:0] k);
    logic [127:0] s;
    s = pt ^ k[127:0];
    for (int r = 1; r < 10; r++) s = mixCols(subShift(s)) ^ k[128*r +: 128];
    return subShift(s) ^ k[1407 -: 128];
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic genBlock(output logic [127:0] pt, output logic [127:0] c, output logic [1407:0] k);
    k = expand({$urandom, $urandom, $urandom, $urandom});
    pt = {$urandom, $urandom, $urandom, $urandom};
    c = encrypt(pt, k);
  endtask

  // called at a negedge; returns at the negedge just after the acceptance edge
  task automatic send(input logic [127:0] c, input logic [1407:0] k, input logic [127:0] pt,
                      input bit scramble);
    int n;
    ct = c;
    ks = k;
    inValid = 1'b1;
    n = 0;
    while (!b1.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!b1.in_ready) begin
      compared++;
      mismatched++;
      $error("FAIL send timeout: in_ready observed 0 expected 1");
    end
    @(posedge clk);
    sb.push_back(pt);
    @(negedge clk);
    inValid = 1'b0;
    if (scramble) begin
      ct = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < 44; i++) ks[32*i +: 32] = $urandom;
    end
  endtask

  task automatic receive(input int expLat, input string tag);
    int n;
    logic [127:0] e;
    n = 0;
    while (!b1.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 128'(n), 128'(expLat));
    e = 'x;
    if (sb.size() > 0) e = sb.pop_front();
    check({tag, " out"}, b1.out, e);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] p, q, x;
    logic [1407:0] ks1, k2;
    logic [127:0] pt2, ct2, o1, o3, o9, curPt, curCt;
    logic [1407:0] curKs;
    int lat1, lat3, lat9, idx, done;
    bit pending, spurious;
    int acc[$];
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q ^= {q[6:0], 1'b0};
      q ^= {q[5:0], 2'b0};
      q ^= {q[3:0], 4'b0};
      if (q[7]) q ^= 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
    ks1 = expand(KEY1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset out", b1.out, '0);
    check("reset out_valid", 128'(b1.out_valid), 128'(0));
    check("reset in_ready", 128'(b1.in_ready), 128'(1));
    rst_n = 1'b1;

    // FIPS-197 C.1 on all three unroll factors at once
    @(negedge clk);
    ct = CT1;
    ks = ks1;
    inValid = 1'b1;
    @(posedge clk);
    sb.push_back(PT1);
    @(negedge clk);
    inValid = 1'b0;
    lat1 = -1;
    lat3 = -1;
    lat9 = -1;
    o1 = '0;
    o3 = '0;
    o9 = '0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (b1.out_valid && lat1 < 0) begin lat1 = n; o1 = b1.out; end
      if (b3.out_valid && lat3 < 0) begin lat3 = n; o3 = b3.out; end
      if (b9.out_valid && lat9 < 0) begin lat9 = n; o9 = b9.out; end
    end
    check("c1 u1 latency", 128'(lat1), 128'(10));
    check("c1 u3 latency", 128'(lat3), 128'(4));
    check("c1 u9 latency", 128'(lat9), 128'(2));
    check("c1 u1 out", o1, sb.pop_front());
    check("c1 u3 out", o3, PT1);
    check("c1 u9 out", o9, PT1);

    // backpressure with a second block waiting on the input
    outReady = 1'b0;
    send(CT1, ks1, PT1, 1'b0);
    receive(10, "bp first");
    genBlock(pt2, ct2, k2);
    ct = ct2;
    ks = k2;
    inValid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      check("bp hold valid", 128'(b1.out_valid), 128'(1));
      check("bp hold out", b1.out, PT1);
      check("bp in_ready", 128'(b1.in_ready), 128'(0));
    end
    outReady = 1'b1;
    @(negedge clk);
    check("bp idle in_ready", 128'(b1.in_ready), 128'(1));
    check("bp cleared valid", 128'(b1.out_valid), 128'(0));
    check("bp out kept", b1.out, PT1);
    @(posedge clk);
    sb.push_back(pt2);
    @(negedge clk);
    inValid = 1'b0;
    receive(10, "bp second");

    // reset while cnt == 5
    @(negedge clk);
    send(CT1, ks1, PT1, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst out", b1.out, '0);
    check("midrst out_valid", 128'(b1.out_valid), 128'(0));
    check("midrst in_ready", 128'(b1.in_ready), 128'(1));
    rst_n = 1'b1;
    sb.delete();
    spurious = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (b1.out_valid) spurious = 1'b1;
    end
    check("midrst no spurious", 128'(spurious), 128'(0));
    send(CT1, ks1, PT1, 1'b0);
    receive(10, "post-reset");

    // inputs scrambled right after acceptance
    @(negedge clk);
    send(CT1, ks1, PT1, 1'b1);
    receive(10, "isolation c1");
    @(negedge clk);
    genBlock(pt2, ct2, k2);
    send(ct2, k2, pt2, 1'b1);
    receive(10, "isolation rnd");

    // 100 random blocks, in_valid kept high, out_ready high
    genBlock(curPt, curCt, curKs);
    ct = curCt;
    ks = curKs;
    inValid = 1'b1;
    idx = 0;
    done = 0;
    pending = 1'b0;
    for (int cyc = 0; cyc < 3000 && done < 100; cyc++) begin
      @(negedge clk);
      if (b1.out_valid) begin
        check("b2b latency", 128'(acc.size() > 0 ? cyc - acc.pop_front() : -1), 128'(10));
        check("b2b out", b1.out, sb.size() > 0 ? sb.pop_front() : 'x);
        done++;
      end
      if (pending) begin
        if (idx < 100) begin
          genBlock(curPt, curCt, curKs);
          ct = curCt;
          ks = curKs;
        end else inValid = 1'b0;
        pending = 1'b0;
      end
      if (inValid && b1.in_ready) begin
        sb.push_back(curPt);
        acc.push_back(cyc + 1);
        idx++;
        pending = 1'b1;
      end
    end
    check("b2b completions", 128'(done), 128'(100));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
